// File: rtl/video_mono_pipe.sv
// Three-stage colour post-processor between the VGA core and the pins.
// Applies mono/sepia modes, a scanline dimmer and blanking, frame-synchronously.
module video_mono_pipe #(
  parameter int CW     = 8,
  parameter int SL_SHR = 1
) (
  input  logic          clk_vga,
  input  logic          reset,
  input  logic [2:0]    mode_req,
  input  logic          scanline_req,
  input  logic [CW-1:0] r_in,
  input  logic [CW-1:0] g_in,
  input  logic [CW-1:0] b_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          hblank_in,
  input  logic          vblank_in,
  output logic [CW-1:0] r_out,
  output logic [CW-1:0] g_out,
  output logic [CW-1:0] b_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          hblank_out,
  output logic          vblank_out,
  output logic [2:0]    mode_act
);

  localparam int SW = CW + 8;
  localparam logic [2:0] M_GREEN = 3'd1;
  localparam logic [2:0] M_AMBER = 3'd2;
  localparam logic [2:0] M_WHITE = 3'd3;
  localparam logic [2:0] M_SEPIA = 3'd4;

  logic [CW-1:0] r1, g1, b1;
  logic          hs1, vs1, hb1, vb1;
  logic [2:0]    mode1;
  logic          sl1, par1;
  logic          vs_rise, hs_rise;

  assign vs_rise = vsync_in & ~vs1;
  assign hs_rise = hsync_in & ~hs1;

  // S1 doubles as the active settings: each pixel is tagged as it enters
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      r1    <= '0;
      g1    <= '0;
      b1    <= '0;
      hs1   <= 1'b0;
      vs1   <= 1'b0;
      hb1   <= 1'b0;
      vb1   <= 1'b0;
      mode1 <= '0;
      sl1   <= 1'b0;
      par1  <= 1'b0;
    end else begin
      r1  <= r_in;
      g1  <= g_in;
      b1  <= b_in;
      hs1 <= hsync_in;
      vs1 <= vsync_in;
      hb1 <= hblank_in;
      vb1 <= vblank_in;
      if (vs_rise) begin
        mode1 <= mode_req;
        sl1   <= scanline_req;
        par1  <= 1'b0;
      end else if (hs_rise) begin
        par1  <= ~par1;
      end
    end
  end

  logic [SW-1:0] sum;
  logic [CW-1:0] r2, g2, b2, y2;
  logic          hs2, vs2, hb2, vb2;
  logic [2:0]    mode2;
  logic          dim2;

  assign sum = SW'(r1) * SW'(54)
             + SW'(g1) * SW'(183)
             + SW'(b1) * SW'(19);

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      r2    <= '0;
      g2    <= '0;
      b2    <= '0;
      y2    <= '0;
      hs2   <= 1'b0;
      vs2   <= 1'b0;
      hb2   <= 1'b0;
      vb2   <= 1'b0;
      mode2 <= '0;
      dim2  <= 1'b0;
    end else begin
      r2    <= r1;
      g2    <= g1;
      b2    <= b1;
      y2    <= CW'(sum >> 8);
      hs2   <= hs1;
      vs2   <= vs1;
      hb2   <= hb1;
      vb2   <= vb1;
      mode2 <= mode1;
      dim2  <= sl1 & par1;
    end
  end

  logic [CW+2:0] y7, y5;
  logic [CW-1:0] rm, gm, bm;
  logic [CW-1:0] rs, gs, bs;

  assign y7 = (CW+3)'(y2) * (CW+3)'(7);
  assign y5 = (CW+3)'(y2) * (CW+3)'(5);

  always_comb begin
    rm = r2;
    gm = g2;
    bm = b2;
    case (mode2)
      M_GREEN: begin
        rm = '0;
        gm = y2;
        bm = '0;
      end
      M_AMBER: begin
        rm = y2;
        gm = y2 >> 1;
        bm = '0;
      end
      M_WHITE: begin
        rm = y2;
        gm = y2;
        bm = y2;
      end
      M_SEPIA: begin
        rm = y2;
        gm = CW'(y7 >> 3);
        bm = CW'(y5 >> 3);
      end
      default: ;
    endcase
    rs = dim2 ? (rm >> SL_SHR) : rm;
    gs = dim2 ? (gm >> SL_SHR) : gm;
    bs = dim2 ? (bm >> SL_SHR) : bm;
    if (hb2 | vb2) begin
      rs = '0;
      gs = '0;
      bs = '0;
    end
  end

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      r_out      <= '0;
      g_out      <= '0;
      b_out      <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblank_out <= 1'b0;
      vblank_out <= 1'b0;
      mode_act   <= '0;
    end else begin
      r_out      <= rs;
      g_out      <= gs;
      b_out      <= bs;
      hsync_out  <= hs2;
      vsync_out  <= vs2;
      hblank_out <= hb2;
      vblank_out <= vb2;
      mode_act   <= mode2;
    end
  end

endmodule

// File: tb/tb_video_mono_pipe.sv
// Bench for video_mono_pipe: directed cases plus random frames
// against a per-pixel arithmetic model delayed three cycles.
module tb_video_mono_pipe;

  localparam int SL = 1;

  logic       clk_vga = 1'b0;
  logic       reset;
  logic [2:0] mode_req;
  logic       scanline_req;
  logic [7:0] r_in, g_in, b_in;
  logic       hsync_in, vsync_in, hblank_in, vblank_in;
  logic [7:0] r_out, g_out, b_out;
  logic       hsync_out, vsync_out, hblank_out, vblank_out;
  logic [2:0] mode_act;

  video_mono_pipe #(.CW(8), .SL_SHR(SL)) dut (
    .clk_vga(clk_vga), .reset(reset),
    .mode_req(mode_req), .scanline_req(scanline_req),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblank_in(hblank_in), .vblank_in(vblank_in),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblank_out(hblank_out), .vblank_out(vblank_out),
    .mode_act(mode_act)
  );

  always #5 clk_vga = ~clk_vga;

  typedef struct {
    int rgb;
    int sync;
    int mode;
  } exp_t;

  exp_t pipe [3];
  int   m_mode, m_sl, m_par, prev_vs, prev_hs;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge();
    exp_t e;
    int r, g, b, y, ro, go, bo;
    if (reset) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{rgb: 0, sync: 0, mode: 0};
      m_mode = 0; m_sl = 0; m_par = 0; prev_vs = 0; prev_hs = 0;
      return;
    end
    if (vsync_in && !prev_vs) begin
      m_mode = int'(mode_req);
      m_sl   = int'(scanline_req);
      m_par  = 0;
    end else if (hsync_in && !prev_hs) begin
      m_par  = 1 - m_par;
    end
    prev_vs = int'(vsync_in);
    prev_hs = int'(hsync_in);
    r = int'(r_in); g = int'(g_in); b = int'(b_in);
    y = (54 * r + 183 * g + 19 * b) / 256;
    case (m_mode)
      1: begin ro = 0; go = y;         bo = 0;         end
      2: begin ro = y; go = y / 2;     bo = 0;         end
      3: begin ro = y; go = y;         bo = y;         end
      4: begin ro = y; go = y * 7 / 8; bo = y * 5 / 8; end
      default: begin ro = r; go = g; bo = b; end
    endcase
    if (m_sl == 1 && m_par == 1) begin
      ro = ro / (2 ** SL); go = go / (2 ** SL); bo = bo / (2 ** SL);
    end
    if (hblank_in || vblank_in) begin
      ro = 0; go = 0; bo = 0;
    end
    e.rgb  = (ro << 16) | (go << 8) | bo;
    e.sync = (int'(hsync_in) << 3) | (int'(vsync_in) << 2)
           | (int'(hblank_in) << 1) | int'(vblank_in);
    e.mode = m_mode;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = e;
  endtask

  task automatic tick();
    @(posedge clk_vga);
    model_edge();
    #1;
    chk("rgb",  {r_out, g_out, b_out}, pipe[2].rgb);
    chk("sync", {hsync_out, vsync_out, hblank_out, vblank_out}, pipe[2].sync);
    chk("mode", mode_act, pipe[2].mode);
  endtask

  task automatic set_mode(input int m, input int s);
    vsync_in = 1'b0;
    tick();
    mode_req = 3'(m);
    scanline_req = s[0];
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    tick();
  endtask

  task automatic hold(input int r, input int g, input int b);
    r_in = 8'(r); g_in = 8'(g); b_in = 8'(b);
    repeat (3) tick();
  endtask

  function automatic int rgb_now();
    return int'({r_out, g_out, b_out});
  endfunction

  initial begin
    reset = 1'b1;
    mode_req = 3'd0; scanline_req = 1'b0;
    r_in = 8'h0; g_in = 8'h0; b_in = 8'h0;
    hsync_in = 1'b0; vsync_in = 1'b0;
    hblank_in = 1'b0; vblank_in = 1'b0;
    for (int i = 0; i < 3; i++) pipe[i] = '{rgb: 0, sync: 0, mode: 0};
    m_mode = 0; m_sl = 0; m_par = 0; prev_vs = 0; prev_hs = 0;
    repeat (2) tick();
    chk("rst_rgb", rgb_now(), 0);
    chk("rst_mode", mode_act, 0);
    reset = 1'b0;
    mode_req = 3'd3;
    tick();

    r_in = 8'h12; g_in = 8'h34; b_in = 8'h56; hsync_in = 1'b1;
    tick();
    r_in = 8'h00; g_in = 8'h00; b_in = 8'h00; hsync_in = 1'b0;
    tick();
    chk("t1_early", rgb_now(), 0);
    tick();
    chk("t1_rgb", rgb_now(), 24'h123456);
    chk("t1_hs", hsync_out, 1);
    chk("t1_mode", mode_act, 0);

    set_mode(3, 0);
    hold(255, 255, 255); chk("white_w", rgb_now(), 24'hFFFFFF);
    hold(255, 0, 0);     chk("white_r", rgb_now(), 24'h353535);
    chk("white_mode", mode_act, 3);
    set_mode(1, 0);
    hold(255, 255, 255); chk("green_w", rgb_now(), 24'h00FF00);
    hold(0, 255, 0);     chk("green_g", rgb_now(), 24'h00B600);
    set_mode(2, 0);
    hold(255, 255, 255); chk("amber_w", rgb_now(), 24'hFF7F00);
    set_mode(4, 0);
    hold(255, 255, 255); chk("sepia_w", rgb_now(), 24'hFFDF9F);
    set_mode(6, 0);
    hold(10, 20, 30);    chk("mode6", rgb_now(), 24'h0A141E);

    set_mode(0, 0);
    hold(255, 255, 255);
    mode_req = 3'd1;
    repeat (4) tick();
    chk("t4_hold", rgb_now(), 24'hFFFFFF);
    chk("t4_hold_m", mode_act, 0);
    vsync_in = 1'b1;
    tick();
    chk("t4_c0", rgb_now(), 24'hFFFFFF);
    tick();
    chk("t4_c1", rgb_now(), 24'hFFFFFF);
    chk("t4_c1_m", mode_act, 0);
    tick();
    chk("t4_green", rgb_now(), 24'h00FF00);
    chk("t4_mode", mode_act, 1);
    vsync_in = 1'b0;
    tick();

    set_mode(3, 1);
    hold(255, 255, 255); chk("sl_even0", rgb_now(), 24'hFFFFFF);
    hsync_in = 1'b1; tick(); hsync_in = 1'b0;
    hold(255, 255, 255); chk("sl_odd", rgb_now(), 24'h7F7F7F);
    hsync_in = 1'b1; tick(); hsync_in = 1'b0;
    hold(255, 255, 255); chk("sl_even1", rgb_now(), 24'hFFFFFF);
    hsync_in = 1'b1; tick(); hsync_in = 1'b0;
    hold(255, 255, 255); chk("sl_odd1", rgb_now(), 24'h7F7F7F);
    set_mode(3, 1);
    hold(255, 255, 255); chk("sl_vs_clr", rgb_now(), 24'hFFFFFF);

    set_mode(0, 0);
    hblank_in = 1'b1;
    hold(255, 255, 255);
    chk("hb_rgb", rgb_now(), 0);
    chk("hb_out", hblank_out, 1);
    hblank_in = 1'b0;
    hold(255, 255, 255);
    chk("hb_end", rgb_now(), 24'hFFFFFF);
    hsync_in = 1'b1;
    r_in = 8'h12; g_in = 8'h34; b_in = 8'h56;
    tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_rgb", rgb_now(), 0);
    chk("rst_mid_sync", {hsync_out, vsync_out, hblank_out, vblank_out}, 0);
    reset = 1'b0;
    hsync_in = 1'b0;
    hold(18, 52, 86);
    chk("rst_track", rgb_now(), 24'h123456);

    for (int f = 0; f < 6; f++) begin
      for (int ln = 0; ln < 12; ln++) begin
        for (int x = 0; x < 24; x++) begin
          reset = ($urandom_range(0, 599) == 0);
          mode_req = 3'($urandom_range(0, 7));
          scanline_req = 1'($urandom_range(0, 1));
          hblank_in = (x >= 16);
          hsync_in = (x >= 18 && x < 21);
          vblank_in = (ln >= 9);
          vsync_in = (ln == 10);
          if (f % 2 == 1) begin
            r_in = 8'hFF; g_in = 8'hFF; b_in = 8'hFF;
          end else begin
            r_in = 8'($urandom_range(0, 255));
            g_in = 8'($urandom_range(0, 255));
            b_in = 8'($urandom_range(0, 255));
          end
          tick();
        end
      end
    end
    reset = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
